// File: rtl/cache_assoc.sv
// cache_assoc: N-way set-associative write-back, write-allocate cache with round-robin victims and hit/miss counters
// clk, r (sync active-high reset)
// cpu2cache_valid/rw/addr/data/wstrb in, cache2cpu_data/ready out: CPU word port
// cache2mem_valid/rw/addr/data out, mem2cache_data/ready in: line-wide memory port
// hit_count, miss_count out: wrapping statistics
module cache_assoc #(
  parameter int ADDR_W = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int SETS = 1024,
  parameter int WAYS = 2
) (
  input  logic                         clk,
  input  logic                         r,
  input  logic                         cpu2cache_valid,
  input  logic                         cpu2cache_rw,
  input  logic [ADDR_W-1:0]            cpu2cache_addr,
  input  logic [31:0]                  cpu2cache_data,
  input  logic [3:0]                   cpu2cache_wstrb,
  output logic [31:0]                  cache2cpu_data,
  output logic                         cache2cpu_ready,
  output logic                         cache2mem_valid,
  output logic                         cache2mem_rw,
  output logic [ADDR_W-1:0]            cache2mem_addr,
  output logic [32*WORDS_PER_LINE-1:0] cache2mem_data,
  input  logic [32*WORDS_PER_LINE-1:0] mem2cache_data,
  input  logic                         mem2cache_ready,
  output logic [31:0]                  hit_count,
  output logic [31:0]                  miss_count
);
  localparam int LINE_W = 32*WORDS_PER_LINE;
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(SETS);
  localparam int LO = OFF_W + 2;
  localparam int TAG_W = ADDR_W - IDX_W - LO;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  typedef enum logic [1:0] {IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE} state_t;
  state_t state;
  logic [ADDR_W-1:0] req_addr;
  logic req_rw;
  logic [31:0] req_data;
  logic [3:0] req_wstrb;
  logic [WAYS-1:0][SETS-1:0] valid, dirty;
  logic [SETS-1:0][WAY_W-1:0] rr;
  logic [TAG_W-1:0] tag_mem [WAYS][SETS];
  logic [LINE_W-1:0] line_mem [WAYS][SETS];
  logic [WAY_W-1:0] vic, hit_way, victim;
  logic hit, after_alloc;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [OFF_W-1:0] word;
  logic [31:0] hit_word, merged;
  logic fill;
  logic unused_addr;
  assign idx = req_addr[LO +: IDX_W];
  assign tag = req_addr[ADDR_W-1 -: TAG_W];
  assign word = req_addr[2 +: OFF_W];
  assign unused_addr = ^req_addr[1:0];
  assign fill = state == ALLOCATE && cache2mem_valid && mem2cache_ready;
  // Descending scan so the lowest-numbered invalid way wins as victim
  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    victim = (WAYS == 1) ? '0 : rr[idx];
    for (int w = WAYS-1; w >= 0; w--) begin
      if (!valid[w][idx]) victim = WAY_W'(w);
      if (valid[w][idx] && tag_mem[w][idx] == tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
    hit_word = line_mem[hit_way][idx][32*word +: 32];
    for (int b = 0; b < 4; b++)
      merged[8*b +: 8] = req_wstrb[b] ? req_data[8*b +: 8] : hit_word[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (r) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      rr <= '0;
      vic <= '0;
      after_alloc <= 1'b0;
      req_addr <= '0;
      req_rw <= 1'b0;
      req_data <= '0;
      req_wstrb <= '0;
      cache2cpu_data <= '0;
      cache2cpu_ready <= 1'b0;
      cache2mem_valid <= 1'b0;
      cache2mem_rw <= 1'b0;
      cache2mem_addr <= '0;
      cache2mem_data <= '0;
      hit_count <= '0;
      miss_count <= '0;
    end else begin
      cache2cpu_ready <= 1'b0;
      case (state)
        IDLE: if (cpu2cache_valid) begin
          req_addr <= cpu2cache_addr;
          req_rw <= cpu2cache_rw;
          req_data <= cpu2cache_data;
          req_wstrb <= cpu2cache_wstrb;
          state <= COMPARE_TAG;
        end
        COMPARE_TAG: if (hit) begin
          if (req_rw) dirty[hit_way][idx] <= 1'b1;
          else cache2cpu_data <= hit_word;
          cache2cpu_ready <= 1'b1;
          if (!after_alloc) hit_count <= hit_count + 32'd1;
          after_alloc <= 1'b0;
          state <= IDLE;
        end else begin
          miss_count <= miss_count + 32'd1;
          vic <= victim;
          cache2mem_valid <= 1'b1;
          cache2mem_data <= line_mem[victim][idx];
          if (valid[victim][idx] && dirty[victim][idx]) begin
            cache2mem_rw <= 1'b1;
            cache2mem_addr <= {tag_mem[victim][idx], idx, {LO{1'b0}}};
            state <= WRITE_BACK;
          end else begin
            cache2mem_rw <= 1'b0;
            cache2mem_addr <= {req_addr[ADDR_W-1:LO], {LO{1'b0}}};
            state <= ALLOCATE;
          end
        end
        WRITE_BACK: if (mem2cache_ready) begin
          cache2mem_valid <= 1'b0;
          state <= ALLOCATE;
        end
        // Entered from WRITE_BACK with valid low: raise the fill after the one-cycle gap
        ALLOCATE: if (!cache2mem_valid) begin
          cache2mem_valid <= 1'b1;
          cache2mem_rw <= 1'b0;
          cache2mem_addr <= {req_addr[ADDR_W-1:LO], {LO{1'b0}}};
        end else if (mem2cache_ready) begin
          cache2mem_valid <= 1'b0;
          valid[vic][idx] <= 1'b1;
          dirty[vic][idx] <= 1'b0;
          rr[idx] <= (WAYS == 1) ? '0 : vic + 1'b1;
          after_alloc <= 1'b1;
          state <= COMPARE_TAG;
        end
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!r && fill) begin
      line_mem[vic][idx] <= mem2cache_data;
      tag_mem[vic][idx] <= tag;
    end
    if (!r && state == COMPARE_TAG && hit && req_rw)
      line_mem[hit_way][idx][32*word +: 32] <= merged;
  end
endmodule

// File: tb/tb_cache_assoc.sv
// tb_cache_assoc: directed and randomized checks of cache_assoc against a flat-memory reference model
module tb_cache_assoc;
  localparam int SETS = 1024;
  localparam int WAYS = 2;
  logic clk = 1'b0;
  logic r = 1'b1;
  logic cpu2cache_valid = 1'b0;
  logic cpu2cache_rw = 1'b0;
  logic [31:0] cpu2cache_addr = '0;
  logic [31:0] cpu2cache_data = '0;
  logic [3:0] cpu2cache_wstrb = '0;
  logic [31:0] cache2cpu_data;
  logic cache2cpu_ready;
  logic cache2mem_valid;
  logic cache2mem_rw;
  logic [31:0] cache2mem_addr;
  logic [127:0] cache2mem_data;
  logic [127:0] mem2cache_data = '0;
  logic mem2cache_ready = 1'b0;
  logic [31:0] hit_count, miss_count;
  always #5 clk = ~clk;
  cache_assoc #(.ADDR_W(32), .WORDS_PER_LINE(4), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk(clk), .r(r),
    .cpu2cache_valid(cpu2cache_valid), .cpu2cache_rw(cpu2cache_rw),
    .cpu2cache_addr(cpu2cache_addr), .cpu2cache_data(cpu2cache_data),
    .cpu2cache_wstrb(cpu2cache_wstrb),
    .cache2cpu_data(cache2cpu_data), .cache2cpu_ready(cache2cpu_ready),
    .cache2mem_valid(cache2mem_valid), .cache2mem_rw(cache2mem_rw),
    .cache2mem_addr(cache2mem_addr), .cache2mem_data(cache2mem_data),
    .mem2cache_data(mem2cache_data), .mem2cache_ready(mem2cache_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );
  int checks = 0;
  int errors = 0;
  int mem_delay = 0;
  logic [127:0] mem [int unsigned];
  logic [31:0] gw [int unsigned];
  bit mv [SETS*WAYS];
  bit md [SETS*WAYS];
  int unsigned mt [SETS*WAYS];
  int rrp [SETS];
  int ehit, emiss;
  logic [31:0] last_rdata, last_wb_addr;
  logic [127:0] last_wb_data;
  int last_nwb, last_nfill;
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [127:0] memline(input int unsigned la);
    logic [127:0] l;
    if (mem.exists(la)) return mem[la];
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = (la + 4*w) ^ 32'hA5C3_0F1E;
    return l;
  endfunction
  function automatic logic [31:0] gword(input int unsigned a);
    logic [127:0] l;
    if (gw.exists(a)) return gw[a];
    l = memline(a & ~32'hF);
    return l[((a >> 2) & 3)*32 +: 32];
  endfunction
  function automatic logic [127:0] gline(input int unsigned la);
    logic [127:0] l;
    for (int w = 0; w < 4; w++) l[w*32 +: 32] = gword(la + 4*w);
    return l;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < SETS*WAYS; i++) begin mv[i] = 0; md[i] = 0; end
    for (int i = 0; i < SETS; i++) rrp[i] = 0;
    ehit = 0;
    emiss = 0;
    gw.delete();
  endtask
  task automatic do_reset();
    @(negedge clk);
    r = 1'b1;
    cpu2cache_valid = 1'b0;
    mem2cache_ready = 1'b0;
    @(negedge clk);
    r = 1'b0;
    model_reset();
    check("rst_ready", 128'(cache2cpu_ready), 128'(0));
    check("rst_memvalid", 128'(cache2mem_valid), 128'(0));
    check("rst_hits", 128'(hit_count), 128'(0));
    check("rst_misses", 128'(miss_count), 128'(0));
    check("rst_cpudata", 128'(cache2cpu_data), 128'(0));
    check("rst_memaddr", 128'(cache2mem_addr), 128'(0));
  endtask
  task automatic req(input bit rw, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    int unsigned set, tg, wa;
    int hw, v, lat, n, mcnt;
    bit wb, got, mrdy;
    logic [31:0] exp_rd, old, nw, wbaddr, fa, r_addr;
    logic [127:0] wbdata, r_data;
    logic r_rw;
    set = (a >> 4) % SETS;
    tg = a >> 14;
    wa = a & ~32'h3;
    fa = a & ~32'hF;
    exp_rd = gword(wa);
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (mv[set*WAYS+w] && mt[set*WAYS+w] == tg) hw = w;
    wb = 0;
    wbaddr = '0;
    wbdata = '0;
    if (hw >= 0) begin
      lat = 2;
      ehit++;
      if (rw) md[set*WAYS+hw] = 1;
    end else begin
      v = -1;
      for (int w = WAYS-1; w >= 0; w--) if (!mv[set*WAYS+w]) v = w;
      if (v < 0) v = rrp[set];
      wb = mv[set*WAYS+v] && md[set*WAYS+v];
      wbaddr = (mt[set*WAYS+v] << 14) | (set << 4);
      wbdata = gline(wbaddr);
      lat = wb ? 6 + 2*mem_delay : 4 + mem_delay;
      emiss++;
      mt[set*WAYS+v] = tg;
      mv[set*WAYS+v] = 1;
      md[set*WAYS+v] = rw;
      rrp[set] = (v + 1) % WAYS;
    end
    if (rw) begin
      old = gword(wa);
      for (int b = 0; b < 4; b++) nw[8*b +: 8] = ws[b] ? wd[8*b +: 8] : old[8*b +: 8];
      gw[wa] = nw;
    end
    @(negedge clk);
    cpu2cache_valid = 1'b1;
    cpu2cache_rw = rw;
    cpu2cache_addr = a;
    cpu2cache_data = wd;
    cpu2cache_wstrb = ws;
    n = 0; mcnt = 0; got = 0; mrdy = 0;
    last_nwb = 0; last_nfill = 0; last_rdata = '0; last_wb_addr = '0; last_wb_data = '0;
    r_rw = 0; r_addr = '0; r_data = '0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      if (cache2cpu_ready) begin
        got = 1;
        last_rdata = cache2cpu_data;
        cpu2cache_valid = 1'b0;
      end else if (mrdy) begin
        mem2cache_ready = 1'b0;
        mrdy = 0;
        mcnt = 0;
        check("mem_gap", 128'(cache2mem_valid), 128'(0));
      end else if (cache2mem_valid) begin
        if (mcnt == 0) begin
          r_rw = cache2mem_rw;
          r_addr = cache2mem_addr;
          r_data = cache2mem_data;
          if (r_rw) begin
            last_nwb++;
            last_wb_addr = r_addr;
            last_wb_data = r_data;
            check("wb_addr", 128'(r_addr), 128'(wbaddr));
            check("wb_data", r_data, wbdata);
          end else begin
            last_nfill++;
            check("fill_addr", 128'(r_addr), 128'(fa));
          end
        end else begin
          check("mem_hold", {cache2mem_rw, cache2mem_addr, cache2mem_data[94:0]}, {r_rw, r_addr, r_data[94:0]});
        end
        if (mcnt == mem_delay) begin
          if (r_rw) mem[r_addr] = r_data;
          else mem2cache_data = memline(r_addr);
          mem2cache_ready = 1'b1;
          mrdy = 1;
        end
        mcnt++;
      end
    end
    cpu2cache_valid = 1'b0;
    mem2cache_ready = 1'b0;
    check("ready_seen", 128'(got), 128'(1));
    check("latency", 128'(n), 128'(lat));
    check("n_writeback", 128'(last_nwb), 128'(wb));
    check("n_fill", 128'(last_nfill), 128'(hw < 0));
    if (!rw) check("rdata", 128'(last_rdata), 128'(exp_rd));
    check("hit_count", 128'(hit_count), 128'(ehit));
    check("miss_count", 128'(miss_count), 128'(emiss));
  endtask
  initial begin
    logic [127:0] l;
    bit seen;
    model_reset();
    do_reset();
    l = {32'h33, 32'h22, 32'h11, 32'h00};
    mem[32'h1000] = l;
    req(0, 32'h0000_1000, 32'h0, 4'h0);
    check("t1_data", 128'(last_rdata), 128'(32'h0));
    check("t1_miss", 128'(miss_count), 128'(1));
    check("t1_hit", 128'(hit_count), 128'(0));
    req(0, 32'h0000_1004, 32'h0, 4'h0);
    check("t2_data", 128'(last_rdata), 128'(32'h11));
    check("t2_hit", 128'(hit_count), 128'(1));
    req(1, 32'h0000_1008, 32'hDEAD_BEEF, 4'b0011);
    req(0, 32'h0000_1008, 32'h0, 4'h0);
    check("t3_data", 128'(last_rdata), 128'(32'h0000_BEEF));
    req(0, 32'h0000_5000, 32'h0, 4'h0);
    check("t4_nowb", 128'(last_nwb), 128'(0));
    req(0, 32'h0000_9000, 32'h0, 4'h0);
    check("t4_wbaddr", 128'(last_wb_addr), 128'(32'h1000));
    l = {32'h33, 32'h0000_BEEF, 32'h11, 32'h00};
    check("t4_wbdata", last_wb_data, l);
    mem_delay = 10;
    req(0, 32'h0000_D000, 32'h0, 4'h0);
    mem_delay = 0;
    req(1, 32'h0000_9004, 32'h1234_5678, 4'hF);
    @(negedge clk);
    cpu2cache_valid = 1'b1;
    cpu2cache_rw = 1'b0;
    cpu2cache_addr = 32'h0000_1000;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = cache2mem_valid && cache2mem_rw;
    end
    check("t6_wb_seen", 128'(seen), 128'(1));
    r = 1'b1;
    cpu2cache_valid = 1'b0;
    @(negedge clk);
    r = 1'b0;
    model_reset();
    check("t6_memvalid", 128'(cache2mem_valid), 128'(0));
    check("t6_hits", 128'(hit_count), 128'(0));
    check("t6_misses", 128'(miss_count), 128'(0));
    check("t6_ready", 128'(cache2cpu_ready), 128'(0));
    req(0, 32'h0000_1000, 32'h0, 4'h0);
    check("t6_remiss", 128'(miss_count), 128'(1));
    check("t6_data", 128'(last_rdata), 128'(32'h0));
    for (int i = 0; i < 300; i++) begin
      mem_delay = $urandom_range(0, 3);
      req($urandom_range(0, 1) == 1,
          ($urandom_range(0, 4) << 14) | ($urandom_range(0, 3) << 4) | $urandom_range(0, 15),
          $urandom, 4'($urandom_range(0, 15)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
